// File: rtl/lsu_mem.sv
// rtl/lsu_mem.sv - load/store memory-access stage with req/gnt/rvalid data bus
module lsu_mem #(
    parameter int CPU_WIDTH = 32,
    parameter int REG_ADDRW = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [3:0]           i_lsu_opt,
    input  logic [CPU_WIDTH-1:0] i_addr,
    input  logic [CPU_WIDTH-1:0] i_wdata,
    input  logic [REG_ADDRW-1:0] i_rdid,
    input  logic                 i_rdwen,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [CPU_WIDTH-1:0] o_rdata,
    output logic [REG_ADDRW-1:0] o_rdid,
    output logic                 o_rdwen,
    output logic                 o_misalign,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [CPU_WIDTH-1:0] o_mem_addr,
    output logic [CPU_WIDTH-1:0] o_mem_wdata,
    output logic [3:0]           o_mem_wstrb,
    input  logic                 i_mem_gnt,
    input  logic                 i_mem_rvalid,
    input  logic [CPU_WIDTH-1:0] i_mem_rdata
);

    localparam logic [3:0] LSU_NOP = 4'b1110;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t state, state_nxt;

    logic [3:0]           opt_q;
    logic [CPU_WIDTH-1:0] addr_q;
    logic [CPU_WIDTH-1:0] wdata_q;
    logic                 accept;
    logic                 in_nop;
    logic                 in_fault;
    logic [CPU_WIDTH-1:0] ld_w;
    logic [CPU_WIDTH-1:0] ld_ext;
    logic [3:0]           st_strb;
    logic [CPU_WIDTH-1:0] st_data;

    assign o_ready = (state == IDLE) | ((state == RESP) & i_ready);
    assign accept  = i_valid & o_ready;
    assign in_nop  = (i_lsu_opt == LSU_NOP);

    // Unsupported encodings are folded into the alignment fault path.
    always_comb begin
        in_fault = 1'b1;
        if (i_lsu_opt[0]) begin
            case (i_lsu_opt[3:1])
                3'b000:  in_fault = 1'b0;
                3'b001:  in_fault = i_addr[0];
                3'b010:  in_fault = |i_addr[1:0];
                default: in_fault = 1'b1;
            endcase
        end else begin
            case (i_lsu_opt[3:1])
                3'b000, 3'b100, 3'b111: in_fault = 1'b0;
                3'b001, 3'b101:         in_fault = i_addr[0];
                3'b010:                 in_fault = |i_addr[1:0];
                default:                in_fault = 1'b1;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (in_nop | in_fault) ? RESP : REQ;
            REQ:  if (i_mem_gnt) state_nxt = opt_q[0] ? RESP : WAIT;
            WAIT: if (i_mem_rvalid) state_nxt = RESP;
            RESP: begin
                if (accept)       state_nxt = (in_nop | in_fault) ? RESP : REQ;
                else if (i_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ld_w = i_mem_rdata >> {addr_q[1:0], 3'b000};
        case (opt_q[3:1])
            3'b000:  ld_ext = {{(CPU_WIDTH-8){ld_w[7]}}, ld_w[7:0]};
            3'b001:  ld_ext = {{(CPU_WIDTH-16){ld_w[15]}}, ld_w[15:0]};
            3'b100:  ld_ext = {{(CPU_WIDTH-8){1'b0}}, ld_w[7:0]};
            3'b101:  ld_ext = {{(CPU_WIDTH-16){1'b0}}, ld_w[15:0]};
            default: ld_ext = ld_w;
        endcase
    end

    always_comb begin
        case (opt_q[3:1])
            3'b000: begin
                st_strb = 4'b0001 << addr_q[1:0];
                st_data = {4{wdata_q[7:0]}};
            end
            3'b001: begin
                st_strb = 4'b0011 << addr_q[1:0];
                st_data = {2{wdata_q[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = wdata_q;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            opt_q      <= 4'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            o_rdid     <= '0;
            o_rdwen    <= 1'b0;
            o_rdata    <= '0;
            o_misalign <= 1'b0;
        end else if (accept) begin
            opt_q      <= i_lsu_opt;
            addr_q     <= i_addr;
            wdata_q    <= i_wdata;
            o_rdid     <= i_rdid;
            o_misalign <= in_fault & ~in_nop;
            o_rdwen    <= i_rdwen & (in_nop | (~in_fault & ~i_lsu_opt[0]));
            o_rdata    <= in_nop ? i_addr : '0;
        end else if ((state == WAIT) && i_mem_rvalid) begin
            o_rdata    <= ld_ext;
        end
    end

    assign o_valid     = (state == RESP);
    assign o_mem_req   = (state == REQ);
    assign o_mem_we    = (state == REQ) & opt_q[0];
    assign o_mem_addr  = {addr_q[CPU_WIDTH-1:2], 2'b00};
    assign o_mem_wdata = st_data;
    assign o_mem_wstrb = ((state == REQ) & opt_q[0]) ? st_strb : 4'b0000;

endmodule
